// File: rtl/cs_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO read-side streamer:
// parameter defaults, FSM state encoding and a wrapping counter helper.
package cs_fifo_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BURST_LEN_DEF = 16;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned OCC_W         = 2;
  localparam int unsigned WORDS_W       = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Increment that wraps back to zero after reaching last.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] last);
    return (v == last) ? '0 : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cs_skid_buf.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
// The caller guarantees no push into a full buffer unless a pop happens too.
module cs_skid_buf
  import cs_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              rdclk,
  input  logic              aclr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] tail;
  logic              pop_ok;

  assign pop_ok = pop && (occ != '0);

  // head always holds the oldest word; tail holds the second when occ == 2
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == '0) head <= din;
          else           tail <= din;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - OCC_W'(1);
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cs_fifo_reader.sv
// Read-side burst fetcher for a dual-clock FIFO: issues reads in bursts of
// BURST_LEN, absorbs the one-cycle read latency and presents a valid/ready stream.
module cs_fifo_reader
  import cs_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic               rdclk,
  input  logic               aclr,
  input  logic               enable,
  input  logic               rdempty,
  input  logic [DATA_W-1:0]  q,
  output logic               rdreq,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic [WORDS_W-1:0] words_out
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] issue_cnt_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [2:0]       pending;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Words that will sit in the buffer after this edge, before any new read.
  assign pending = 3'(occ) + 3'(inflight) - 3'(pop);
  assign rdreq   = (state != ST_IDLE) && !rdempty && (pending < 3'd2);

  assign issue_cnt_nxt = rdreq ? wrap_inc(issue_cnt, LAST_BEAT) : issue_cnt;

  assign m_last = m_valid && (beat_cnt == LAST_BEAT);
  assign busy   = (state != ST_IDLE) || m_valid || inflight;

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Leaving RUN looks at the post-read count so a read landing in the same
  // cycle as enable falling is still completed as a whole burst.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_nxt = (issue_cnt_nxt == '0) ? ST_IDLE : ST_FINISH;
      end
      ST_FINISH: begin
        if (rdreq && (issue_cnt == LAST_BEAT)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      issue_cnt <= issue_cnt_nxt;
      inflight  <= rdreq;
      if (pop) begin
        beat_cnt  <= wrap_inc(beat_cnt, LAST_BEAT);
        words_out <= words_out + WORDS_W'(1);
      end
    end
  end

  cs_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .rdclk(rdclk),
    .aclr (aclr),
    .push (inflight),
    .din  (q),
    .pop  (pop),
    .occ  (occ),
    .head (m_data)
  );

endmodule

// File: tb/tb_cs_fifo_reader.sv
// Self-checking bench for cs_fifo_reader: behavioural FIFO with one-cycle read
// latency, in-order scoreboard and burst-position model for m_last.
module tb_cs_fifo_reader;

  localparam int unsigned BL = 16;

  logic        rdclk = 1'b0;
  logic        aclr;
  logic        enable;
  logic        rdempty;
  logic [31:0] q;
  logic        rdreq;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [31:0] words_out;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_q[$];
  int unsigned reads_acc = 0;
  int unsigned xfers = 0;
  int          cycle = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [31:0] first_word = '0;

  cs_fifo_reader dut (
    .rdclk    (rdclk),
    .aclr     (aclr),
    .enable   (enable),
    .rdempty  (rdempty),
    .q        (q),
    .rdreq    (rdreq),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .words_out(words_out)
  );

  always #5 rdclk = ~rdclk;

  // FIFO model: read accepted on the edge, data registered onto q.
  always @(posedge rdclk) begin
    cycle++;
    if (!aclr && rdreq && !rdempty) begin
      q <= fifo_q.pop_front();
      reads_acc++;
    end
    #2 rdempty = (fifo_q.size() == 0);
  end

  // Stream scoreboard, sampled mid-cycle.
  always @(negedge rdclk) begin
    if (!aclr) begin
      tests_run++;
      if (rdreq && rdempty) begin
        tests_failed++;
        $display("FAIL underflow: rdreq=1 while rdempty=1 at cycle %0d", cycle);
      end
      tests_run++;
      if (words_out !== 32'(xfers)) begin
        tests_failed++;
        $display("FAIL words_out: got %0d expected %0d", words_out, xfers);
      end
      if (m_valid && m_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_word: got %0h expected no word", m_data);
        end else if (m_data !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL order: got %0h expected %0h", m_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        tests_run++;
        if (m_last !== ((xfers % BL) == BL - 1)) begin
          tests_failed++;
          $display("FAIL m_last: got %0b expected %0b at word %0d",
                   m_last, ((xfers % BL) == BL - 1), xfers);
        end
        if (m_last) last_q.push_back(m_data);
        if (xfers == 0) begin
          first_cyc  = cycle;
          first_word = m_data;
        end
        last_cyc = cycle;
        xfers++;
      end
    end
  end

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    last_q.delete();
    xfers     = 0;
    reads_acc = 0;
  endtask

  task automatic do_reset();
    aclr    = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    clear_model();
    tick();
    tick();
    aclr = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // mode 0: hold m_ready, 1: toggle, 2: random
  task automatic wait_xfers(input int unsigned n, input int budget, input int mode,
                            input string name);
    int k = 0;
    while (xfers < n && k < budget) begin
      tick();
      k++;
      if (mode == 1)      m_ready = ~m_ready;
      else if (mode == 2) m_ready = 1'($urandom_range(1, 0));
    end
    if (xfers < n) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got %0d words expected %0d", name, xfers, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    m_ready = 1'b1;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy=%0b expected 0", name, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({rdreq, m_valid, m_last, busy} !== 4'b0 || m_data !== 32'h0 || words_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s: got rdreq=%0b m_valid=%0b m_last=%0b busy=%0b m_data=%0h words_out=%0d expected all 0",
               name, rdreq, m_valid, m_last, busy, m_data, words_out);
    end
  endtask

  task automatic test_reset();
    aclr    = 1'b1;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'(i + 1));
    repeat (3) tick();
    check_all_zero("reset_outputs");
    tests_run++;
    if (reads_acc !== 0) begin
      tests_failed++;
      $display("FAIL reset_reads: got %0d expected 0", reads_acc);
    end
    enable = 1'b0;
    aclr   = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (rdreq !== 1'b0 || busy !== 1'b0 || reads_acc !== 0) begin
      tests_failed++;
      $display("FAIL idle_no_issue: got rdreq=%0b busy=%0b reads=%0d expected 0 0 0",
               rdreq, busy, reads_acc);
    end
  endtask

  task automatic test_full_rate();
    int c_en;
    do_reset();
    for (int i = 1; i <= 32; i++) push_word(32'(i));
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    c_en    = cycle;
    wait_xfers(32, 200, 0, "full_rate");
    tests_run++;
    if (first_cyc != c_en + 3) begin
      tests_failed++;
      $display("FAIL fill_latency: got %0d expected %0d", first_cyc - c_en, 3);
    end
    tests_run++;
    if (last_cyc - first_cyc != 31) begin
      tests_failed++;
      $display("FAIL throughput: got %0d cycles expected 31", last_cyc - first_cyc);
    end
    tests_run++;
    if (last_q.size() != 2 || last_q[0] !== 32'h10 || last_q[1] !== 32'h20) begin
      tests_failed++;
      $display("FAIL last_markers: got %0d markers first %0h expected 2 at 10,20",
               last_q.size(), (last_q.size() > 0) ? last_q[0] : 32'hx);
    end
    enable = 1'b0;
    wait_idle(50, "full_rate");
    tests_run++;
    if (words_out !== 32'd32) begin
      tests_failed++;
      $display("FAIL words_out_32: got %0d expected 32", words_out);
    end
  endtask

  task automatic test_ready_pattern(input int mode);
    logic [31:0] w[32];
    do_reset();
    for (int i = 0; i < 32; i++) begin
      w[i] = 32'($urandom());
      push_word(w[i]);
    end
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_xfers(32, 400, mode, "ready_pattern");
    tests_run++;
    if (exp_q.size() != 0 || last_q.size() != 2 ||
        last_q[0] !== w[15] || last_q[1] !== w[31]) begin
      tests_failed++;
      $display("FAIL ready_pattern_%0d: got %0d left %0d markers expected 0 left 2 markers",
               mode, exp_q.size(), last_q.size());
    end
    enable = 1'b0;
    wait_idle(50, "ready_pattern");
  endtask

  task automatic test_enable_drop();
    int k = 0;
    do_reset();
    for (int i = 0; i < 40; i++) push_word(32'($urandom()));
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    while (reads_acc < 5 && k < 100) begin
      tick();
      k++;
    end
    tests_run++;
    if (reads_acc !== 5) begin
      tests_failed++;
      $display("FAIL drop_point: got %0d reads expected 5", reads_acc);
    end
    enable = 1'b0;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
      m_ready = 1'($urandom_range(1, 0));
    end
    tests_run++;
    if (busy !== 1'b0 || xfers !== 16 || exp_q.size() != 24) begin
      tests_failed++;
      $display("FAIL busy_fall: got busy=%0b words=%0d left=%0d expected 0 16 24",
               busy, xfers, exp_q.size());
    end
    repeat (10) tick();
    tests_run++;
    if (reads_acc !== 16 || fifo_q.size() != 24) begin
      tests_failed++;
      $display("FAIL finish_reads: got %0d expected 16", reads_acc);
    end
  endtask

  task automatic test_empty_mid();
    logic [31:0] w16;
    do_reset();
    for (int i = 0; i < 7; i++) push_word(32'($urandom()));
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_xfers(7, 200, 2, "empty_mid");
    m_ready = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (m_valid !== 1'b0 || rdreq !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_stall: got m_valid=%0b rdreq=%0b busy=%0b expected 0 0 1",
               m_valid, rdreq, busy);
    end
    for (int i = 0; i < 9; i++) begin
      w16 = 32'($urandom());
      push_word(w16);
    end
    wait_xfers(16, 200, 2, "empty_resume");
    tests_run++;
    if (last_q.size() != 1 || last_q[0] !== w16) begin
      tests_failed++;
      $display("FAIL resume_last: got %0d markers expected 1 on %0h", last_q.size(), w16);
    end
    enable = 1'b0;
    wait_idle(50, "empty_mid");
  endtask

  task automatic test_aclr_mid();
    do_reset();
    for (int i = 1; i <= 16; i++) push_word(32'(i));
    tick();
    enable  = 1'b1;
    m_ready = 1'b0;
    repeat (8) tick();
    tests_run++;
    if (m_valid !== 1'b1 || reads_acc !== 2) begin
      tests_failed++;
      $display("FAIL pre_aclr: got m_valid=%0b reads=%0d expected 1 2", m_valid, reads_acc);
    end
    aclr    = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b1;
    clear_model();
    #1;
    check_all_zero("aclr_immediate");
    tick();
    aclr = 1'b0;
    for (int i = 0; i < 16; i++) push_word(32'hA0 + 32'(i));
    tick();
    enable = 1'b1;
    wait_xfers(16, 200, 0, "aclr_refill");
    tests_run++;
    if (first_word !== 32'hA0 || last_q.size() != 1 || last_q[0] !== 32'hAF) begin
      tests_failed++;
      $display("FAIL aclr_refill: got first %0h markers %0d expected A0 and 1 on AF",
               first_word, last_q.size());
    end
    enable = 1'b0;
    wait_idle(50, "aclr_mid");
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 16; i++) push_word(32'(i));
    tick();
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_valid) begin
        tests_run++;
        if (m_data !== 32'h1) begin
          tests_failed++;
          $display("FAIL stall_data: got %0h expected 1", m_data);
        end
      end
    end
    tests_run++;
    if (reads_acc > 2 || m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_reads: got %0d reads m_valid=%0b expected <=2 and 1",
               reads_acc, m_valid);
    end
    wait_xfers(16, 200, 2, "stall_drain");
    enable = 1'b0;
    wait_idle(50, "stall");
  endtask

  initial begin
    aclr    = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    rdempty = 1'b1;
    q       = '0;
    test_reset();
    test_full_rate();
    test_ready_pattern(1);
    test_ready_pattern(2);
    test_enable_drop();
    test_empty_mid();
    test_aclr_mid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cs_fifo_reader.md
CS_FIFO_READER -- requirements
Module: cs_fifo_reader

Interface
REQ-001 Parameter DATA_W, default 32, word width; matches the dual-clock FIFO wrapper q width.
REQ-002 Parameter BURST_LEN, default 16, words per burst; legal range 2..65535.
REQ-003 rdclk  input  1  read-domain clock; all logic on rising edge.
REQ-004 aclr  input  1  reset, asynchronous, active-high; same net that resets the FIFO wrapper.
REQ-005 enable  input  1  level; 1 = fetch bursts from FIFO.
REQ-006 rdempty  input  1  FIFO empty flag, rdclk domain.
REQ-007 q  input  DATA_W  FIFO registered read data.
REQ-008 rdreq  output  1  FIFO read request.
REQ-009 m_data  output  DATA_W  stream data.
REQ-010 m_valid  output  1  stream valid.
REQ-011 m_ready  input  1  stream ready from sink.
REQ-012 m_last  output  1  marks final word of each burst.
REQ-013 busy  output  1  1 when state != IDLE or any word in flight or buffered.
REQ-014 words_out  output  32  count of words transferred on stream (m_valid && m_ready).

Function
REQ-015 Read accepted at edge k iff rdreq=1 and rdempty=0 sampled; the word is valid on q in the cycle after edge k and is captured internally at edge k+1 (fixed read latency 1).
REQ-016 rdreq shall never be 1 while rdempty=1 (no underflow).
REQ-017 Internal 2-entry skid buffer plus 1-bit inflight flag; rdreq = issue_ok && !rdempty && (occ + inflight - pop) < 2, pop = m_valid && m_ready (combinational in m_ready).
REQ-018 With m_ready held 1 and FIFO non-empty, throughput is one word per rdclk after 2-cycle fill latency.
REQ-019 m_valid = (occ != 0); m_data = oldest buffered word; m_data/m_last held stable while m_valid && !m_ready.
REQ-020 Words leave the stream in FIFO order; none dropped or duplicated under any m_ready pattern.
REQ-021 States IDLE, RUN, FINISH; issue_ok = (state != IDLE).
REQ-022 IDLE -> RUN when enable=1.
REQ-023 RUN -> IDLE when enable=0 and issue counter = 0; RUN -> FINISH when enable=0 and issue counter != 0.
REQ-024 FINISH -> IDLE on the accepted read that wraps issue counter BURST_LEN-1 -> 0; enable ignored in FINISH.
REQ-025 Issue counter (16 bit) increments per accepted read, wraps at BURST_LEN-1 -> 0.
REQ-026 Output beat counter (16 bit) increments per stream transfer, wraps at BURST_LEN-1 -> 0; m_last = m_valid && beat counter = BURST_LEN-1.
REQ-027 Buffered/in-flight words continue draining in IDLE.
REQ-028 words_out wraps 2^32-1 -> 0.
REQ-029 FIFO empty mid-burst: rdreq low, state unchanged, resume when rdempty=0.
REQ-030 Simultaneous push and pop with occ=2 cannot occur (guaranteed by REQ-017); push and pop same cycle with occ=1 leaves occ=1.

Reset
REQ-031 aclr=1 forces immediately: state IDLE, occ 0, inflight 0, both counters 0, words_out 0, m_valid 0, m_last 0, m_data 0, busy 0, rdreq 0.
REQ-032 aclr mid-burst discards buffered and in-flight words; the next burst after release starts at beat 0.
REQ-033 No state changes on rdclk while aclr=1.

Structure
REQ-034 State encoding (IDLE/RUN/FINISH) and DATA_W/BURST_LEN defaults placed in shared package cs_fifo_pkg.
REQ-035 Skid buffer implemented as sub-module cs_skid_buf (push, data in, pop, occ, head data); FSM and counters in top.

Verification
REQ-036 FIFO preloaded 0x1..0x20, enable=1, m_ready=1 -> 32 words in order, one per cycle after fill, m_last on 0x10 and 0x20, words_out=32.
REQ-037 Same preload, m_ready toggling 1010... -> identical data order, no loss/duplication, rdreq never with rdempty=1.
REQ-038 enable dropped after 5th accepted read -> FINISH, exactly 16 reads total, then IDLE, busy falls after last word out.
REQ-039 FIFO empties after 7 words mid-burst -> rdreq low, m_valid low after drain; 9 more words written -> burst completes with m_last on 16th.
REQ-040 aclr pulsed with occ=2 mid-burst -> all outputs 0 immediately; refill 0xA0..0xAF, enable=1 -> m_last on 0xAF.
REQ-041 m_ready=0 for 50 cycles with FIFO full -> at most 2 reads accepted, m_data stable 0x1.
